// File: rtl/driver_lampada_pwm.sv
// rtl/driver_lampada_pwm.sv - lamp PWM driver with soft-start/soft-stop brightness ramps
module driver_lampada_pwm #(
    parameter int PWM_DIV  = 4,
    parameter int STEP_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       liga,
    input  logic [7:0] brilho_max,
    output logic       pwm_out,
    output logic [7:0] nivel,
    output logic       acesa,
    output logic       em_rampa
);

    localparam int STEP_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int PRE_W  = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_DIV - 1);
    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(PWM_DIV - 1);

    typedef enum logic [1:0] {
        APAGADA  = 2'd0,
        SUBINDO  = 2'd1,
        ACESA    = 2'd2,
        DESCENDO = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [7:0]        nivel_next;
    logic              liga_meta;
    logic              liga_s;
    logic [STEP_W-1:0] step_cnt;
    logic              tick;
    logic [PRE_W-1:0]  pwm_pre;
    logic              pwm_wrap;
    logic [7:0]        pwm_cnt;

    // liga comes from the slow controller domain; two flops before any decision uses it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            liga_meta <= 1'b0;
            liga_s    <= 1'b0;
        end else begin
            liga_meta <= liga;
            liga_s    <= liga_meta;
        end
    end

    assign tick = (step_cnt == STEP_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            step_cnt <= '0;
        end else if (tick) begin
            step_cnt <= '0;
        end else begin
            step_cnt <= step_cnt + 1'b1;
        end
    end

    assign pwm_wrap = (pwm_pre == PRE_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pwm_pre <= '0;
            pwm_cnt <= 8'd0;
        end else begin
            if (pwm_wrap) begin
                pwm_pre <= '0;
                pwm_cnt <= pwm_cnt + 8'd1;
            end else begin
                pwm_pre <= pwm_pre + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= APAGADA;
            nivel   <= 8'd0;
            pwm_out <= 1'b0;
        end else begin
            state   <= state_next;
            nivel   <= nivel_next;
            pwm_out <= (pwm_cnt < nivel);
        end
    end

    // Transitions take priority over stepping, so a tick in a transition cycle is dropped
    always_comb begin
        state_next = state;
        nivel_next = nivel;
        case (state)
            APAGADA: begin
                nivel_next = 8'd0;
                if (liga_s) begin
                    state_next = SUBINDO;
                end
            end
            SUBINDO: begin
                if (!liga_s) begin
                    state_next = DESCENDO;
                end else if (nivel >= brilho_max) begin
                    state_next = ACESA;
                end else if (tick && (nivel != 8'hFF)) begin
                    nivel_next = nivel + 8'd1;
                end
            end
            ACESA: begin
                if (!liga_s) begin
                    state_next = DESCENDO;
                end else if (tick) begin
                    if ((nivel < brilho_max) && (nivel != 8'hFF)) begin
                        nivel_next = nivel + 8'd1;
                    end else if ((nivel > brilho_max) && (nivel != 8'd0)) begin
                        nivel_next = nivel - 8'd1;
                    end
                end
            end
            DESCENDO: begin
                if (liga_s) begin
                    state_next = SUBINDO;
                end else if (nivel == 8'd0) begin
                    state_next = APAGADA;
                end else if (tick) begin
                    nivel_next = nivel - 8'd1;
                end
            end
            default: begin
                state_next = APAGADA;
                nivel_next = 8'd0;
            end
        endcase
    end

    assign acesa    = (state == ACESA);
    assign em_rampa = (state == SUBINDO) || (state == DESCENDO);

endmodule
